// File: rtl/register_dump_controller.sv
// Dumps the register bank through read port A as a byte stream, LSB first,
// over a valid/ready interface towards the debug UART transmitter.
module register_dump_controller #(
    parameter int REG_WIDTH     = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int DUMP_COUNT    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [REG_ADDR_BITS-1:0] rf_addr,
    input  logic [REG_WIDTH-1:0]     rf_data,
    output logic                     rf_owner,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int NBYTES = REG_WIDTH / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WCW    = REG_ADDR_BITS + 1;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(DUMP_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_t;

    state_t               state;
    logic [REG_WIDTH-1:0] shift_reg;
    logic [BCW-1:0]       byte_cnt;
    logic [WCW-1:0]       word_cnt;

    // The low byte of the shift register is the byte on offer.
    assign tx_data = shift_reg[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            shift_reg <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            rf_addr   <= '0;
            rf_owner  <= 1'b0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StRead;
                        rf_addr  <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        rf_owner <= 1'b1;
                    end
                end
                StRead: begin
                    // Bank drove rf_data on the falling edge of this cycle.
                    shift_reg <= rf_data;
                    byte_cnt  <= '0;
                    tx_valid  <= 1'b1;
                    state     <= StSend;
                end
                StSend: begin
                    if (tx_ready) begin
                        shift_reg <= shift_reg >> 8;
                        byte_cnt  <= byte_cnt + BCW'(1);
                        if (byte_cnt == LAST_BYTE) begin
                            tx_valid <= 1'b0;
                            if (word_cnt == LAST_WORD) begin
                                state <= StDone;
                                done  <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + WCW'(1);
                                rf_addr  <= rf_addr + REG_ADDR_BITS'(1);
                                state    <= StRead;
                            end
                        end
                    end
                end
                StDone: begin
                    state    <= StIdle;
                    busy     <= 1'b0;
                    rf_owner <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump_controller.sv
// Self-checking bench: vector table plus hand sequences, byte stream checked
// against a model built from the bank contents.
module tb_register_dump_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_1;
    logic [4:0]  rf_addr, rf_addr_1;
    logic [31:0] rf_data, rf_data_1;
    logic        rf_owner, rf_owner_1;
    logic [7:0]  tx_data, tx_data_1;
    logic        tx_valid, tx_valid_1;
    logic        tx_ready, tx_ready_1;
    logic        busy, busy_1;
    logic        done, done_1;

    register_dump_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
        .rf_owner(rf_owner), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    register_dump_controller #(.REG_WIDTH(32), .REG_ADDR_BITS(5), .DUMP_COUNT(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .rf_addr(rf_addr_1), .rf_data(rf_data_1),
        .rf_owner(rf_owner_1), .tx_data(tx_data_1), .tx_valid(tx_valid_1),
        .tx_ready(tx_ready_1), .busy(busy_1), .done(done_1)
    );

    always #5 clk = ~clk;

    logic [31:0] bank [32];
    logic [31:0] bank_1 [32];
    logic [7:0]  cap[$], cap_1[$], exp_q[$];
    int          n_tests = 0, n_fail = 0;
    int          edge_cnt = 0, done_cnt = 0, done1_cnt = 0, addr1_bad = 0;
    int          ready_mode = 0;
    bit          hold_pending = 0;
    logic [7:0]  hold_byte;

    typedef struct {
        int pattern;      // bank contents
        int rmode;        // 0 high, 1 toggle, 2 random
        int exp_bytes;
        int exp_done_off; // -1 when tx_ready is not held high
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fill_bank(input int pattern);
        for (int i = 0; i < 32; i++) begin
            case (pattern)
                0: bank[i] = {4{8'(i)}};
                1: bank[i] = (i == 5) ? 32'hDEADBEEF : 32'h0;
                2: bank[i] = $urandom;
                default: bank[i] = (i % 2 == 1) ? 32'hFFFFFFFF : 32'h00FF00FF;
            endcase
        end
    endtask

    task automatic compare_stream(input string name, input int reps);
        int nbad, n;
        exp_q.delete();
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < 32; i++)
                for (int b = 0; b < 4; b++) exp_q.push_back(bank[i][8*b +: 8]);
        check({name, "_len"}, cap.size(), exp_q.size());
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        nbad = 0;
        for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) nbad++;
        check({name, "_bad_bytes"}, nbad, 0);
    endtask

    task automatic kick(output int k);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 k = edge_cnt; start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int d, output bit ok);
        ok = 1'b0;
        d = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done) begin
                d = edge_cnt; ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_send_addr(input logic [4:0] a, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (tx_valid && rf_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_addr_timeout", 0, 1);
    endtask

    // Bank models: read data changes on the falling edge.
    initial forever begin
        @(negedge clk);
        rf_data   = bank[rf_addr];
        rf_data_1 = bank_1[rf_addr_1];
    end

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            2: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    // Monitor: capture accepted bytes and check the hold rule.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                n_tests++;
                if (!tx_valid || tx_data !== hold_byte) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%0b data=%h, expected valid=1 data=%h",
                             tx_valid, tx_data, hold_byte);
                end
            end
            hold_pending = tx_valid && !tx_ready;
            hold_byte    = tx_data;
            if (tx_valid && tx_ready) cap.push_back(tx_data);
            if (done) done_cnt++;
            if (tx_valid_1 && tx_ready_1) cap_1.push_back(tx_data_1);
            if (busy_1 && rf_addr_1 != 5'd0) addr1_bad++;
            if (done_1) done1_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  k, d, dc0, nbad;
        bit  ok;
        logic [7:0] stall_byte;

        rst_n = 1'b0; start = 1'b0; start_1 = 1'b0; tx_ready = 1'b0; tx_ready_1 = 1'b1;
        for (int i = 0; i < 32; i++) bank_1[i] = 32'hAAAAAAAA;
        bank_1[0] = 32'h12345678;
        fill_bank(0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {rf_addr, tx_data, tx_valid, busy, rf_owner, done}, 17'h0);
        check("reset_outputs_1", {rf_addr_1, tx_data_1, tx_valid_1, busy_1, rf_owner_1, done_1},
              17'h0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_without_start", {busy, tx_valid}, 2'b00);

        vecs[0] = '{pattern: 0, rmode: 0, exp_bytes: 128, exp_done_off: 160};
        vecs[1] = '{pattern: 1, rmode: 1, exp_bytes: 128, exp_done_off: -1};
        vecs[2] = '{pattern: 2, rmode: 2, exp_bytes: 128, exp_done_off: -1};
        vecs[3] = '{pattern: 2, rmode: 0, exp_bytes: 128, exp_done_off: 160};
        vecs[4] = '{pattern: 3, rmode: 2, exp_bytes: 128, exp_done_off: -1};

        for (int v = 0; v < 5; v++) begin
            fill_bank(vecs[v].pattern);
            ready_mode = vecs[v].rmode;
            repeat (2) @(negedge clk);
            cap.delete();
            dc0 = done_cnt;
            kick(k);
            if (vecs[v].exp_done_off >= 0) begin
                @(negedge clk);
                check("latency_busy_owner_addr", {busy, rf_owner, rf_addr, tx_valid}, 8'hC0);
                @(negedge clk);
                check("latency_first_byte", {tx_valid, tx_data}, {1'b1, bank[0][7:0]});
            end
            wait_done($sformatf("vec%0d", v), d, ok);
            if (ok && vecs[v].exp_done_off >= 0)
                check("done_edge", d - k, vecs[v].exp_done_off);
            @(negedge clk);
            check("busy_after_done", {busy, rf_owner}, 2'b00);
            check("done_pulses", done_cnt - dc0, 1);
            check("vec_byte_count", cap.size(), vecs[v].exp_bytes);
            compare_stream($sformatf("vec%0d_stream", v), 1);
            if (vecs[v].pattern == 1 && cap.size() >= 24)
                check("deadbeef_bytes", {cap[23], cap[22], cap[21], cap[20]}, 32'hDEADBEEF);
        end

        // Stall 50 cycles in the middle of word 3.
        fill_bank(2);
        ready_mode = 0;
        repeat (2) @(negedge clk);
        cap.delete();
        kick(k);
        wait_send_addr(5'd3, ok);
        ready_mode = 3;
        @(negedge clk);
        stall_byte = tx_data;
        check("stall_byte", stall_byte, bank[3][15:8]);
        nbad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!tx_valid || rf_addr != 5'd3 || tx_data !== stall_byte) nbad++;
        end
        check("stall_hold", nbad, 0);
        ready_mode = 0;
        wait_done("stall", d, ok);
        @(negedge clk);
        compare_stream("stall_stream", 1);

        // start held across the end of a dump: back-to-back second dump.
        fill_bank(2);
        cap.delete();
        dc0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        wait_done("held1", d, ok);
        @(negedge clk);
        check("held_idle_after_done", busy, 1'b0);
        @(negedge clk);
        check("held_back_to_back", busy, 1'b1);
        start = 1'b0;
        wait_done("held2", d, ok);
        @(negedge clk);
        check("held_done_pulses", done_cnt - dc0, 2);
        compare_stream("held_stream", 2);

        // Re-pulsed mid-dump then held, but dropped at done: exactly one dump.
        fill_bank(3);
        cap.delete();
        dc0 = done_cnt;
        kick(k);
        repeat (40) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        wait_done("repulse", d, ok);
        start = 1'b0;
        nbad = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) nbad++;
        end
        check("repulse_no_restart", nbad, 0);
        check("repulse_done_pulses", done_cnt - dc0, 1);
        compare_stream("repulse_stream", 1);

        // Reset during the second byte of word 7.
        fill_bank(2);
        cap.delete();
        kick(k);
        wait_send_addr(5'd7, ok);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("midreset_outputs", {rf_addr, tx_data, tx_valid, busy, rf_owner, done}, 17'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_idle", busy, 1'b0);
        cap.delete();
        dc0 = done_cnt;
        kick(k);
        wait_done("after_reset", d, ok);
        if (ok) check("after_reset_done_edge", d - k, 160);
        @(negedge clk);
        check("after_reset_done_pulses", done_cnt - dc0, 1);
        compare_stream("after_reset_stream", 1);

        // Single-register dump.
        cap_1.delete();
        addr1_bad = 0;
        @(posedge clk); #1 start_1 = 1'b1;
        @(posedge clk); #1 k = edge_cnt; start_1 = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done_1) begin
                d = edge_cnt; ok = 1'b1;
                break;
            end
        end
        check("dc1_done_seen", ok, 1'b1);
        if (ok) check("dc1_done_edge", d - k, 5);
        @(negedge clk);
        check("dc1_busy_after", busy_1, 1'b0);
        check("dc1_byte_count", cap_1.size(), 4);
        if (cap_1.size() >= 4)
            check("dc1_bytes", {cap_1[3], cap_1[2], cap_1[1], cap_1[0]}, 32'h12345678);
        check("dc1_addr_stays_0", addr1_bad, 0);
        check("dc1_done_pulses", done1_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_dump_controller.md
# register_dump_controller

Sequencer that reads the whole register bank through one read port and streams each word out as bytes over a valid/ready byte interface, least-significant byte first. It sits between the register bank and the debug UART transmitter. While dumping it owns the register-bank read-port-A address through an external mux selected by `rf_owner`. It is used when the processor is halted, to return the full register file contents to the host.

## Interface
Parameters:
- `REG_WIDTH`, default 32: register word width; must be a multiple of 8.
- `REG_ADDR_BITS`, default 5: register address width.
- `DUMP_COUNT`, default 32: number of registers dumped, addresses 0 to `DUMP_COUNT`-1; legal range 1 to 2**`REG_ADDR_BITS`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `rf_addr`  out  `REG_ADDR_BITS`  read address to the register bank port A; registered.
- `rf_data`  in  `REG_WIDTH`  register bank port A data; the bank updates it on the falling edge.
- `rf_owner`  out  1  high while the controller owns port A (mux select).
- `tx_data`  out  8  byte to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts the byte this cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the last byte has been accepted.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - `start`=1 → READ, with `rf_addr`<=0 and `word_cnt`<=0.
  - `start`=0 → stay in IDLE.
- READ (exactly 1 cycle):
  - `rf_addr` is stable for the full cycle, so the bank's falling-edge read returns the addressed word mid-cycle.
  - On the next rising edge, `rf_data` is latched into a `REG_WIDTH` shift register and `byte_cnt`<=0; state → SEND.
- SEND:
  - `tx_valid`=1 and `tx_data`=shift[7:0].
  - On `tx_valid`&`tx_ready`: shift right by 8 and increment `byte_cnt`.
  - Last byte accepted (`byte_cnt`=`REG_WIDTH`/8-1):
    - If `word_cnt`=`DUMP_COUNT`-1 → DONE.
    - Otherwise `word_cnt`++, `rf_addr`++ and → READ.
- DONE (1 cycle): `done`=1, then → IDLE.
- `rf_owner` equals `busy`.
- `start` asserted while not in IDLE is ignored; it is not queued.
- Counters: `byte_cnt` is `$clog2(REG_WIDTH/8)` bits wide; `word_cnt` is `REG_ADDR_BITS`+1 bits wide, so `DUMP_COUNT`=2**`REG_ADDR_BITS` does not overflow. `rf_addr` never wraps past `DUMP_COUNT`-1.
- The controller never writes the register bank.

## Timing
- Reset (asynchronous, any state, including mid-dump): state=IDLE, `rf_addr`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `rf_owner`=0, `done`=0, all counters=0.
  - A partially sent word is dropped.
  - After reset release, a new `start` restarts the dump from address 0.
- Handshake:
  - Once `tx_valid` is raised, it stays high and `tx_data` stays constant until `tx_ready` is sampled high.
  - `tx_valid` is never high outside SEND.
  - `tx_ready` is ignored outside SEND.
- Latency, taking `start` sampled at edge k:
  - `busy`, `rf_owner` and `rf_addr`=0 are valid after edge k.
  - The first byte is valid after edge k+1.
- Throughput:
  - With `tx_ready` held high, one word takes `REG_WIDTH`/8+1 cycles (5 for 32-bit).
  - The last byte of the 32-register default dump is accepted at edge k+160.
  - `done` is high between edges k+160 and k+161; `busy` falls after edge k+161.
- A new `start` is accepted in the first IDLE cycle after DONE, giving back-to-back dumps.

## Test plan
- Reset, then bank preloaded with reg[i]={i,i,i,i} and `tx_ready`=1, `start` pulse → 128 bytes 00 00 00 00 01 01 01 01 … 1F 1F 1F 1F; `done` pulse at edge k+160; `busy` low after edge k+161.
- reg[5]=0xDEADBEEF, all other registers 0, `tx_ready` toggling 1-0-1-0 → bytes 20-23 are EF BE AD DE. `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0; no byte is lost or duplicated.
- `tx_ready`=0 for 50 cycles during word 3 → controller holds in SEND with `rf_addr`=3 and the same byte on `tx_data`; the dump resumes correctly.
- `start` held high throughout and re-pulsed mid-dump → exactly one dump of 128 bytes. A second dump begins in the IDLE cycle after `done` only if `start` is still high there.
- `rst_n` low during the second byte of word 7 → all outputs are at reset values immediately. A new `start` after release dumps from address 0 with no leftover bytes.
- `DUMP_COUNT`=1, reg[0]=0x12345678 → bytes 78 56 34 12, then `done`; `rf_addr` stays 0 throughout.
